// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and instruction-fetch request sequencer.
// A redirect arriving while the instruction memory is busy is parked in a
// pending register and applied as soon as the memory frees up.
// A FLUSH pulse accompanies every PC load from a redirect.
// Optional build macro: MISALIGN_CHECK_EN. When it is defined, a redirect
// target with bits [1:0] != 0 loads TRAP_VECTOR and pulses MISALIGN.
//
// state | meaning
// BOOT  | first cycle after reset, PC = RESET_VECTOR, no request
// RUN   | fetching: PC advances, holds on STALL, or takes a redirect
// WAIT  | memory busy: PC held until IMEM_BUSY drops
// PEND  | redirect parked while busy: no request, load target when free
module pc_fetch_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            STALL,
  input  logic            IMEM_BUSY,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_4,
  output logic            IMEM_REQ,
  output logic            PC_VALID,
  output logic            FLUSH,
  output logic            MISALIGN
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    PEND = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] load_tgt;
  logic            load;
  logic            req_q, req_d;
  logic            flush_q;

  assign PC       = pc_q;
  assign PC_4     = pc_q + XLEN'(4);
  assign IMEM_REQ = req_q;
  assign PC_VALID = req_q & ~IMEM_BUSY;
  assign FLUSH    = flush_q;

  // Next-state, next-PC and pending-target selection.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    load     = 1'b0;
    load_tgt = REDIRECT_PC;
    pc_d     = pc_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN, WAIT: begin
        if (REDIRECT && !IMEM_BUSY) begin
          load    = 1'b1;
          state_d = RUN;
        end else if (REDIRECT) begin
          pend_d  = REDIRECT_PC;
          state_d = PEND;
        end else if (IMEM_BUSY) begin
          state_d = WAIT;
        end else if (state_q == WAIT) begin
          // held PC is accepted this cycle; resume without advancing
          state_d = RUN;
        end else if (!STALL) begin
          pc_d = PC_4;
        end
      end
      PEND: begin
        // latest redirect wins, even on the cycle the memory frees up
        if (REDIRECT) pend_d = REDIRECT_PC;
        if (!IMEM_BUSY) begin
          load     = 1'b1;
          load_tgt = REDIRECT ? REDIRECT_PC : pend_q;
          state_d  = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if (load) pc_d = load_tgt;
`ifdef MISALIGN_CHECK_EN
    if (load && (load_tgt[1:0] != 2'b00)) pc_d = TRAP_VECTOR;
`endif
    req_d = (state_d == RUN) || (state_d == WAIT);
  end

  // State, PC, pending target and registered request/flush.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      req_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      flush_q <= load;
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic mis_q;
  assign MISALIGN = mis_q;

  // Misalign pulse registered alongside the trap load.
  always_ff @(posedge CLK) begin
    if (RESET) mis_q <= 1'b0;
    else       mis_q <= load && (load_tgt[1:0] != 2'b00);
  end
`else
  assign MISALIGN = 1'b0;
  // TRAP_VECTOR stays in the parameter list but has no function in this build.
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural fetch model. Honours MISALIGN_CHECK_EN.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] TV = 32'h100;

  logic        CLK = 1'b0;
  logic        RESET, STALL, IMEM_BUSY, REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] PC, PC_4;
  logic        IMEM_REQ, PC_VALID, FLUSH, MISALIGN;

  logic       RESET8 = 1'b1;
  logic       zero1 = 1'b0;
  logic [7:0] zero8 = 8'h00;
  logic [7:0] pc8, pc4_8;
  logic       req8, valid8, flush8, mis8;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model
  logic        m_boot = 1'b1, m_wait = 1'b0, m_pv = 1'b0, m_req = 1'b0;
  logic        m_flush = 1'b0, m_mis = 1'b0;
  logic [31:0] m_pc = RV, m_pend = '0;

  always #5 CLK = ~CLK;

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .IMEM_BUSY(IMEM_BUSY),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .PC(PC), .PC_4(PC_4),
    .IMEM_REQ(IMEM_REQ), .PC_VALID(PC_VALID), .FLUSH(FLUSH), .MISALIGN(MISALIGN)
  );

  pc_fetch_ctrl #(.XLEN(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h40)) dut8 (
    .CLK(CLK), .RESET(RESET8), .STALL(zero1), .IMEM_BUSY(zero1),
    .REDIRECT(zero1), .REDIRECT_PC(zero8), .PC(pc8), .PC_4(pc4_8),
    .IMEM_REQ(req8), .PC_VALID(valid8), .FLUSH(flush8), .MISALIGN(mis8)
  );

  function automatic logic [31:0] eff_pc(input logic [31:0] t);
`ifdef MISALIGN_CHECK_EN
    return (t[1:0] != 2'b00) ? TV : t;
`else
    return t;
`endif
  endfunction

  function automatic logic eff_mis(input logic [31:0] t);
`ifdef MISALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One clock of the fetch rules, using the inputs applied for that edge.
  task automatic model_step();
    m_flush = 1'b0;
    m_mis   = 1'b0;
    if (RESET) begin
      m_boot = 1'b1; m_wait = 1'b0; m_pv = 1'b0; m_pend = '0;
      m_pc = RV; m_req = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_req = 1'b1;
    end else if (m_pv) begin
      if (REDIRECT) m_pend = REDIRECT_PC;
      if (!IMEM_BUSY) begin
        m_pc = eff_pc(m_pend); m_mis = eff_mis(m_pend);
        m_flush = 1'b1; m_pv = 1'b0; m_req = 1'b1;
      end
    end else if (REDIRECT && !IMEM_BUSY) begin
      m_pc = eff_pc(REDIRECT_PC); m_mis = eff_mis(REDIRECT_PC);
      m_flush = 1'b1; m_wait = 1'b0;
    end else if (REDIRECT) begin
      m_pv = 1'b1; m_pend = REDIRECT_PC; m_req = 1'b0; m_wait = 1'b0;
    end else if (IMEM_BUSY) begin
      m_wait = 1'b1;
    end else if (m_wait) begin
      m_wait = 1'b0;
    end else if (!STALL) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic set_in(input logic r, input logic s, input logic b,
                        input logic rd, input logic [31:0] t);
    RESET = r; STALL = s; IMEM_BUSY = b; REDIRECT = rd; REDIRECT_PC = t;
  endtask

  // Advance one clock; leaves time at the following falling edge.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    n_tests++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", PC, 32'h0); end
    n_tests++; if (IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", IMEM_REQ); end
    n_tests++; if (FLUSH !== 1'b0 || MISALIGN !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got flush=%b mis=%b expected 0 0", FLUSH, MISALIGN); end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++; if (PC_VALID !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b expected 0", PC_VALID); end
    tick();
    n_tests++; if (PC !== 32'h0 || IMEM_REQ !== 1'b1) begin n_fail++; $display("FAIL first_run: got pc=%h req=%b expected 00000000 1", PC, IMEM_REQ); end
    tick();
    n_tests++; if (PC !== 32'h4) begin n_fail++; $display("FAIL inc_4: got %h expected %h", PC, 32'h4); end
    tick();
    n_tests++; if (PC !== 32'h8) begin n_fail++; $display("FAIL inc_8: got %h expected %h", PC, 32'h8); end
  endtask

  task automatic test_stall();
    tick();
    tick();
    n_tests++; if (PC !== 32'h10) begin n_fail++; $display("FAIL pre_stall_pc: got %h expected %h", PC, 32'h10); end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (PC !== 32'h10 || PC_VALID !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got pc=%h valid=%b expected 00000010 1", i, PC, PC_VALID); end
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    n_tests++; if (PC !== 32'h14) begin n_fail++; $display("FAIL post_stall_pc: got %h expected %h", PC, 32'h14); end
  endtask

  task automatic test_pend();
    int flushes;
    flushes = 0;
    tick(); tick(); tick();
    n_tests++; if (PC !== 32'h20) begin n_fail++; $display("FAIL pre_pend_pc: got %h expected %h", PC, 32'h20); end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    n_tests++; if (PC_VALID !== 1'b0) begin n_fail++; $display("FAIL busy_valid: got %b expected 0", PC_VALID); end
    tick();
    flushes += int'(FLUSH);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    tick();
    flushes += int'(FLUSH);
    n_tests++; if (PC !== 32'h20 || IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL pend_enter: got pc=%h req=%b expected 00000020 0", PC, IMEM_REQ); end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h90);
    tick();
    flushes += int'(FLUSH);
    n_tests++; if (PC !== 32'h20) begin n_fail++; $display("FAIL pend_hold: got %h expected %h", PC, 32'h20); end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++; if (PC_VALID !== 1'b0) begin n_fail++; $display("FAIL pend_valid: got %b expected 0", PC_VALID); end
    tick();
    flushes += int'(FLUSH);
    n_tests++; if (PC !== 32'h90 || FLUSH !== 1'b1) begin n_fail++; $display("FAIL pend_load: got pc=%h flush=%b expected 00000090 1", PC, FLUSH); end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    flushes += int'(FLUSH);
    n_tests++; if (PC !== 32'h94) begin n_fail++; $display("FAIL pend_next: got %h expected %h", PC, 32'h94); end
    n_tests++; if (flushes != 1) begin n_fail++; $display("FAIL pend_flush_count: got %0d expected 1", flushes); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_mis;
    exp_pc  = eff_pc(32'h42);
    exp_mis = eff_mis(32'h42);
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h42);
    tick();
    n_tests++; if (PC !== exp_pc || FLUSH !== 1'b1 || MISALIGN !== exp_mis) begin n_fail++; $display("FAIL misalign_redirect: got pc=%h flush=%b mis=%b expected %h 1 %b", PC, FLUSH, MISALIGN, exp_pc, exp_mis); end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    n_tests++; if (PC !== exp_pc + 32'd4 || FLUSH !== 1'b0 || MISALIGN !== 1'b0) begin n_fail++; $display("FAIL misalign_after: got pc=%h flush=%b mis=%b expected %h 0 0", PC, FLUSH, MISALIGN, exp_pc + 32'd4); end
  endtask

  task automatic test_reset_in_pend();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    tick();
    n_tests++; if (IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL rp_enter: got req=%b expected 0", IMEM_REQ); end
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    n_tests++; if (PC !== RV || IMEM_REQ !== 1'b0 || FLUSH !== 1'b0) begin n_fail++; $display("FAIL rp_reset: got pc=%h req=%b flush=%b expected %h 0 0", PC, IMEM_REQ, FLUSH, RV); end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    n_tests++; if (PC !== RV || IMEM_REQ !== 1'b1 || FLUSH !== 1'b0) begin n_fail++; $display("FAIL rp_run: got pc=%h req=%b flush=%b expected %h 1 0", PC, IMEM_REQ, FLUSH, RV); end
    tick();
    n_tests++; if (PC !== RV + 32'd4 || FLUSH !== 1'b0) begin n_fail++; $display("FAIL rp_discard: got pc=%h flush=%b expected %h 0", PC, FLUSH, RV + 32'd4); end
  endtask

  task automatic test_wrap();
    n_tests++; if (pc8 !== 8'hF8 || req8 !== 1'b0) begin n_fail++; $display("FAIL wrap_boot: got pc=%h req=%b expected f8 0", pc8, req8); end
    RESET8 = 1'b0;
    tick();
    n_tests++; if (pc8 !== 8'hF8 || req8 !== 1'b1) begin n_fail++; $display("FAIL wrap_run: got pc=%h req=%b expected f8 1", pc8, req8); end
    tick();
    n_tests++; if (pc8 !== 8'hFC || pc4_8 !== 8'h00) begin n_fail++; $display("FAIL wrap_fc: got pc=%h pc4=%h expected fc 00", pc8, pc4_8); end
    tick();
    n_tests++; if (pc8 !== 8'h00) begin n_fail++; $display("FAIL wrap_00: got %h expected 00", pc8); end
    tick();
    n_tests++; if (pc8 !== 8'h04 || flush8 !== 1'b0 || mis8 !== 1'b0 || valid8 !== 1'b1) begin n_fail++; $display("FAIL wrap_04: got pc=%h flush=%b mis=%b valid=%b expected 04 0 0 1", pc8, flush8, mis8, valid8); end
  endtask

  task automatic test_random();
    logic        r, s, b, rd;
    logic [31:0] t;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 5) == 0);
      t  = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      set_in(r, s, b, rd, t);
      #1;
      n_tests++; if (PC_VALID !== (m_req & ~b)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, PC_VALID, m_req & ~b); end
      tick();
      n_tests++; if (PC !== m_pc || PC_4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pc[%0d]: got pc=%h pc4=%h expected %h %h", i, PC, PC_4, m_pc, m_pc + 32'd4); end
      n_tests++; if (IMEM_REQ !== m_req || FLUSH !== m_flush || MISALIGN !== m_mis) begin n_fail++; $display("FAIL rnd_ctl[%0d]: got req=%b flush=%b mis=%b expected %b %b %b", i, IMEM_REQ, FLUSH, MISALIGN, m_req, m_flush, m_mis); end
    end
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_stall();
    test_pend();
    test_misalign();
    test_reset_in_pend();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
